// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer onto a single-port synchronous memory.
// Define MEM_PORT_ARBITER_RR_EN for round-robin tie-break; default is fixed priority (r0 wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              en_q, en_d, we_q, we_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant, win;
  assign grant = (state_q == IDLE) && (r0_req || r1_req);
`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_q, last_d;
  // ties go to whoever was not granted last; lone requesters always win
  assign win    = (r0_req && r1_req) ? ~last_q : ~r0_req;
  assign last_d = grant ? win : last_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign win = ~r0_req;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    if (grant) begin
      state_d = ACCESS;
      owner_d = win;
      gnt0_d  = ~win;
      gnt1_d  = win;
      en_d    = 1'b1;
      we_d    = win ? r1_we : r0_we;
      addr_d  = win ? r1_addr : r0_addr;
      wdata_d = we_d ? (win ? r1_wdata : r0_wdata) : '0;
    end else if (state_q == ACCESS) begin
      state_d = we_q ? IDLE : RESP;
      rv0_d   = ~we_q & ~owner_q;
      rv1_d   = ~we_q & owner_q;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end
  assign r0_gnt    = gnt0_q;
  assign r1_gnt    = gnt1_q;
  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  assign r0_rdata  = rv0_q ? mem_rdata : '0;
  assign r1_rdata  = rv1_q ? mem_rdata : '0;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of mem_port_arbiter against a transaction-level model.
// Honours MEM_PORT_ARBITER_RR_EN the same way the design does.
module tb_mem_port_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       mem_en, mem_we, busy, owner;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // synchronous memory with one-cycle read latency
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // transaction model: one transaction granted at cycle g, idle again from end_c
  logic [7:0] ref_mem [256];
  int         cyc, vec, errs, g, end_c;
  logic       t_who, t_we, last, e_gnt0, e_gnt1;
  logic [7:0] t_addr, t_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic mreset();
    g = -10; end_c = 0; last = 1'b1; t_who = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
  endtask

  task automatic check_all();
    logic acc, resp, bsy;
    acc  = cyc == g;
    resp = (cyc == g + 1) && !t_we;
    bsy  = cyc >= g && cyc < end_c;
    e_gnt0 = acc && !t_who;
    e_gnt1 = acc && t_who;
    chk("r0_gnt", r0_gnt, e_gnt0);
    chk("r1_gnt", r1_gnt, e_gnt1);
    chk("mem_en", mem_en, acc);
    chk("mem_we", mem_we, acc && t_we);
    chk("mem_addr", mem_addr, acc ? t_addr : 8'h00);
    if (!acc || t_we) chk("mem_wdata", mem_wdata, acc ? t_wdata : 8'h00);
    chk("r0_rvalid", r0_rvalid, resp && !t_who);
    chk("r1_rvalid", r1_rvalid, resp && t_who);
    chk("r0_rdata", r0_rdata, (resp && !t_who) ? ref_mem[t_addr] : 8'h00);
    chk("r1_rdata", r1_rdata, (resp && t_who) ? ref_mem[t_addr] : 8'h00);
    chk("busy", busy, bsy);
    if (bsy) chk("owner", owner, t_who);
    if (acc && t_we) ref_mem[t_addr] = t_wdata;
  endtask

  task automatic tick();
    if (!reset && cyc >= end_c && (r0_req || r1_req)) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      t_who = (r0_req && r1_req) ? ~last : r1_req;
`else
      t_who = r1_req && !r0_req;
`endif
      last    = t_who;
      t_we    = t_who ? r1_we : r0_we;
      t_addr  = t_who ? r1_addr : r0_addr;
      t_wdata = t_who ? r1_wdata : r0_wdata;
      g       = cyc + 1;
      end_c   = g + (t_we ? 1 : 2);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic op(input bit i, input bit we, input logic [7:0] a, input logic [7:0] d, output int gc);
    if (i) begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
    else   begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
    gc = -1;
    for (int k = 0; k < 20 && gc < 0; k++) begin
      tick();
      if (i ? e_gnt1 : e_gnt0) gc = cyc;
    end
    chk("grant_seen", gc >= 0, 1);
    if (i) r1_req = 0; else r0_req = 0;
  endtask

  initial begin
    int c0, gc, gc0, gc1, n;
    int wins [6];
    bit p0, p1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    vec = 0; errs = 0; cyc = 0;
    mreset();
    reset = 1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
    reset = 0;

    // r0 write 0x5A -> 0x10
    c0 = cyc;
    op(0, 1, 8'h10, 8'h5A, gc);
    chk("w_lat", gc, c0 + 1);
    chk("w_addr", mem_addr, 8'h10);
    chk("w_data", mem_wdata, 8'h5A);
    chk("w_we", {mem_en, mem_we}, 2'b11);
    tick();
    chk("w_busy_low", busy, 0);

    // r1 read 0x10
    c0 = cyc;
    op(1, 0, 8'h10, 8'h00, gc);
    chk("r_lat", gc, c0 + 1);
    tick();
    chk("r_rvalid", r1_rvalid, 1);
    chk("r_rdata", r1_rdata, 8'h5A);
    chk("r_r0_quiet", r0_rvalid, 0);
    tick();

    // both requesting continuously
    n = 0;
    r0_req = 1; r0_we = 0; r0_addr = 8'h01;
    r1_req = 1; r1_we = 0; r1_addr = 8'h02;
    for (int k = 0; k < 40 && n < 6; k++) begin
      tick();
      if (r0_gnt) begin wins[n] = 0; n++; r0_addr = 8'($urandom_range(0, 127)); end
      else if (r1_gnt) begin wins[n] = 1; n++; r1_addr = 8'($urandom_range(0, 127)); end
    end
    chk("tie_count", n, 6);
    for (int k = 0; k < 6; k++)
`ifdef MEM_PORT_ARBITER_RR_EN
      chk("tie_rr", wins[k], k % 2);
`else
      chk("tie_fixed", wins[k], 0);
`endif
    r0_req = 0; r1_req = 0;
    repeat (4) tick();

    // r1 arrives during r0 read ACCESS: granted right after r0 completes
    op(0, 0, 8'h20, 8'h00, gc0);
    op(1, 0, 8'h10, 8'h00, gc1);
    chk("b2b_gnt", gc1, gc0 + 3);
    repeat (3) tick();

    // reset during RESP of a read
    op(0, 0, 8'h30, 8'h00, gc);
    tick();
    chk("pre_rst_rvalid", r0_rvalid, 1);
    reset = 1;
    #1;
    chk("mid_rst_rvalid", r0_rvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_rdata", r0_rdata, 0);
    mreset();
    tick();
    reset = 0;
    op(0, 0, 8'hFF, 8'h00, gc);
    tick();
    chk("ff_rvalid", r0_rvalid, 1);
    chk("ff_rdata", r0_rdata, 8'hFC);
    tick();

    // one-cycle r0 pulse while busy is lost
    op(1, 0, 8'h40, 8'h00, gc);
    r0_req = 1; r0_we = 0; r0_addr = 8'h50;
    tick();
    r0_req = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pulse_nogrant", r0_gnt, 0);
    end
    chk("pulse_idle", {busy, mem_en}, 0);

    // randomized traffic
    p0 = 0; p1 = 0;
    for (int k = 0; k < 1500; k++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; r0_req = 1; r0_we = 1'($urandom_range(0, 1));
        r0_addr = 8'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00);
        r0_wdata = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; r1_req = 1; r1_we = 1'($urandom_range(0, 1));
        r1_addr = 8'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00);
        r1_wdata = 8'($urandom);
      end
      tick();
      if (e_gnt0) begin p0 = 0; r0_req = 0; end
      if (e_gnt1) begin p1 = 0; r1_req = 0; end
    end
    r0_req = 0; r1_req = 0;
    repeat (4) tick();
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU's single-port 256-byte data memory. Requester 0 is the CPU core (instruction fetch and LOAD/STORE/ADD/SUB operand access). Requester 1 is the external program loader or debug port. The block serialises their accesses onto one synchronous memory port with a one-cycle read latency, and returns read data to the owning requester.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 bytes)
- DATA_W, 8, data width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  requester 0 access request; held until r0_gnt
- r0_we  in  1  requester 0 write (1) / read (0)
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_gnt  out  1  one-cycle grant pulse to requester 0
- r0_rvalid  out  1  requester 0 read data valid, one cycle
- r0_rdata  out  DATA_W  requester 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- busy  out  1  high whenever state is not IDLE
- owner  out  1  requester that owns the current transaction (0/1)

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - Arbitrate among asserted rN_req.
  - The winner's we/addr/wdata are registered into mem_we/mem_addr/mem_wdata.
  - owner <= winner; rN_gnt of the winner goes high; state moves to ACCESS.
  - With no request, state stays IDLE.
- **ACCESS:**
  - mem_en=1 and rN_gnt=1 for the owner, for exactly this cycle.
  - Write: next state is IDLE.
  - Read: next state is RESP.
- **RESP:**
  - r{owner}_rvalid=1 and r{owner}_rdata=mem_rdata (combinational pass-through).
  - Next state is IDLE.
- Requests are ignored in ACCESS and RESP. Losing and new requests wait in IDLE.
- A requester must hold req and its fields stable until it sees gnt. It may present its next request in the cycle after gnt.
- Non-owner rvalid is always 0. rdata of a non-owner, and rdata outside RESP, is 0.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
- A requester that drops req before gnt loses that request. No error is flagged.
- Tie-break rule: see Configuration.

## Timing
- Write latency: request sampled in IDLE at edge N, gnt and mem write during cycle N+1, back in IDLE at N+2. Two cycles per write.
- Read latency: gnt during cycle N+1, rvalid/rdata during cycle N+2, back in IDLE at N+3. Three cycles per read.
- Back-to-back: a new arbitration happens on the first IDLE cycle after a transaction, with no extra bubble.
- Reset values: state IDLE; busy, owner, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, r0_rdata, r1_rdata = 0; last-grant register = 1.
- Reset mid-transaction:
  - All outputs go to reset values immediately (asynchronously).
  - The in-flight transaction is dropped and no rvalid is issued.
  - A write whose mem_en was already asserted in that cycle may or may not complete. Software must not rely on it.
- Release from reset: the first arbitration occurs on the first rising edge with reset low.

## Configuration
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin tie-break.
  - When both request in IDLE, grant the requester that is not last-grant.
  - last-grant updates on every grant.
  - After reset, r0 wins the first tie.
- Undefined: fixed priority. r0 always wins ties; r1 is granted only when r0_req=0 in IDLE. The last-grant register is not implemented.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset, then r0 writes 0x5A to addr 0x10 → r0_gnt one cycle after request; mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0x5A in that cycle; busy low two cycles after request.
- r1 reads addr 0x10 (memory model returns 0x5A) → r1_gnt at +1 cycle, r1_rvalid=1 and r1_rdata=0x5A at +2, r0_rvalid stays 0.
- r0 and r1 both request continuously with RR_EN defined → grants alternate r0, r1, r0, r1. With RR_EN undefined → r0 granted every transaction and r1 never.
- r1 requests during an r0 read's ACCESS cycle → r1 waits; r1_gnt comes in the cycle right after the r0 RESP+IDLE arbitration, with no extra idle cycle.
- reset asserted during RESP of a read → r0_rvalid, busy and mem_en drop in the same cycle. After release, a fresh r0 read to 0xFF completes normally with data from address 0xFF.
- Pulse r0_req for one cycle while busy → no grant, no memory access; state returns to IDLE and stays there.
